// File: rtl/regfile_arbiter.sv
// Two-requester round-robin arbiter with burst lock in front of a shared register file.
// Ops are accepted one per cycle and return read data two edges after acceptance.
module regfile_arbiter #(
   parameter int unsigned MAX_BURST = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req0,
   input  logic        req1,
   input  logic        lock0,
   input  logic        lock1,
   input  logic        we0,
   input  logic        we1,
   input  logic [15:0] wdata0,
   input  logic [15:0] wdata1,
   input  logic [3:0]  waddr0,
   input  logic [3:0]  waddr1,
   input  logic [3:0]  raddr_a0,
   input  logic [3:0]  raddr_a1,
   input  logic [3:0]  raddr_b0,
   input  logic [3:0]  raddr_b1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        rvalid0,
   output logic        rvalid1,
   output logic [15:0] rdata_a,
   output logic [15:0] rdata_b,
   output logic        rf_write,
   output logic [15:0] rf_D,
   output logic [3:0]  rf_DA,
   output logic [3:0]  rf_AA,
   output logic [3:0]  rf_BA,
   input  logic [15:0] rf_A,
   input  logic [15:0] rf_B
);

   localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

   logic       ptr;        // requester favoured when both request
   logic       last_id;    // requester granted at the most recent accepting edge
   logic [3:0] burst_cnt;  // consecutive grants to last_id, 0 after an idle cycle
   logic       s1_valid;
   logic       s1_id;
   logic       s2_valid;
   logic       s2_id;

   logic       hold;
   logic       accept;
   logic       gid;

   always_comb begin
      hold = 1'b0;
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (last_id == 1'b0)
         hold = req0 & lock0 & (burst_cnt < BURST_MAX);
      else
         hold = req1 & lock1 & (burst_cnt < BURST_MAX);
      // Nothing may be accepted on a reset edge, so grants are suppressed.
      if (!reset) begin
         if (hold) begin
            gnt0 = ~last_id;
            gnt1 = last_id;
         end else if (req0 && req1) begin
            gnt0 = ~ptr;
            gnt1 = ptr;
         end else begin
            gnt0 = req0;
            gnt1 = req1;
         end
      end
   end

   assign accept = gnt0 | gnt1;
   assign gid    = gnt1;

   always_ff @(posedge clock) begin
      if (reset) begin
         ptr       <= 1'b0;
         last_id   <= 1'b0;
         burst_cnt <= 4'd0;
         rf_write  <= 1'b0;
         rf_D      <= 16'd0;
         rf_DA     <= 4'd0;
         rf_AA     <= 4'd0;
         rf_BA     <= 4'd0;
         s1_valid  <= 1'b0;
         s1_id     <= 1'b0;
         s2_valid  <= 1'b0;
         s2_id     <= 1'b0;
         rvalid0   <= 1'b0;
         rvalid1   <= 1'b0;
         rdata_a   <= 16'd0;
         rdata_b   <= 16'd0;
      end else begin
         if (accept) begin
            ptr     <= ~gid;
            last_id <= gid;
            if (burst_cnt != 4'd0 && gid == last_id)
               burst_cnt <= (burst_cnt >= BURST_MAX) ? BURST_MAX : burst_cnt + 4'd1;
            else
               burst_cnt <= 4'd1;
            rf_write <= gid ? we1      : we0;
            rf_D     <= gid ? wdata1   : wdata0;
            rf_DA    <= gid ? waddr1   : waddr0;
            rf_AA    <= gid ? raddr_a1 : raddr_a0;
            rf_BA    <= gid ? raddr_b1 : raddr_b0;
         end else begin
            burst_cnt <= 4'd0;
            rf_write  <= 1'b0;
         end

         // The register file captures its read data one edge after acceptance.
         s1_valid <= accept;
         s1_id    <= gid;
         s2_valid <= s1_valid;
         s2_id    <= s1_id;
         rvalid0  <= s2_valid & ~s2_id;
         rvalid1  <= s2_valid & s2_id;
         if (s2_valid) begin
            rdata_a <= rf_A;
            rdata_b <= rf_B;
         end
      end
   end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter: hand-computed grants and read-back data,
// returns checked by a scoreboard monitor against a behavioural register file.
module tb_regfile_arbiter;

   logic        clock;
   logic        reset;
   logic        req0, req1, lock0, lock1, we0, we1;
   logic [15:0] wdata0, wdata1;
   logic [3:0]  waddr0, waddr1, raddr_a0, raddr_a1, raddr_b0, raddr_b1;
   logic        gnt0, gnt1, rvalid0, rvalid1;
   logic [15:0] rdata_a, rdata_b;
   logic        rf_write;
   logic [15:0] rf_D;
   logic [3:0]  rf_DA, rf_AA, rf_BA;
   logic [15:0] rf_A, rf_B;

   logic [15:0] rf_mem [16];

   typedef struct {
      logic        id;
      logic [15:0] a;
      logic [15:0] b;
      int unsigned t;
   } ret_t;
   ret_t sb[$];

   logic [15:0] exp0_a, exp0_b, exp1_a, exp1_b;
   int total = 0;
   int bad   = 0;

   regfile_arbiter #(.MAX_BURST(4)) dut (
      .clock(clock), .reset(reset),
      .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
      .we0(we0), .we1(we1), .wdata0(wdata0), .wdata1(wdata1),
      .waddr0(waddr0), .waddr1(waddr1),
      .raddr_a0(raddr_a0), .raddr_a1(raddr_a1),
      .raddr_b0(raddr_b0), .raddr_b1(raddr_b1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata_a(rdata_a), .rdata_b(rdata_b),
      .rf_write(rf_write), .rf_D(rf_D), .rf_DA(rf_DA), .rf_AA(rf_AA), .rf_BA(rf_BA),
      .rf_A(rf_A), .rf_B(rf_B)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Register file: write and registered read on the same edge, read sees old data.
   initial begin
      for (int i = 0; i < 16; i++) rf_mem[i] = 16'd0;
      rf_A = 16'd0;
      rf_B = 16'd0;
   end
   always @(posedge clock) begin
      if (rf_write) rf_mem[rf_DA] <= rf_D;
      rf_A <= rf_mem[rf_AA];
      rf_B <= rf_mem[rf_BA];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      if (rvalid0 && rvalid1) begin
         total++;
         bad++;
         $display("FAIL rvalid_excl: got both high expected at most one at %0t", $time);
      end
      if (rvalid0 || rvalid1) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rvalid_unexpected: got rvalid0=%0b rvalid1=%0b expected none at %0t",
                     rvalid0, rvalid1, $time);
         end else begin
            ret_t e;
            e = sb.pop_front();
            chk("ret_id", {31'd0, rvalid1}, {31'd0, e.id});
            chk("ret_rdata_a", {16'd0, rdata_a}, {16'd0, e.a});
            chk("ret_rdata_b", {16'd0, rdata_b}, {16'd0, e.b});
            chk("ret_time", 32'($time), e.t);
         end
      end
   end

   task automatic set_op0(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                          input logic [3:0] ra, input logic [3:0] rb,
                          input logic [15:0] ea, input logic [15:0] eb);
      we0 = we; waddr0 = wa; wdata0 = wd; raddr_a0 = ra; raddr_b0 = rb;
      exp0_a = ea; exp0_b = eb;
   endtask

   task automatic set_op1(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                          input logic [3:0] ra, input logic [3:0] rb,
                          input logic [15:0] ea, input logic [15:0] eb);
      we1 = we; waddr1 = wa; wdata1 = wd; raddr_a1 = ra; raddr_b1 = rb;
      exp1_a = ea; exp1_b = eb;
   endtask

   // Called at a negedge: drive one cycle, check the grant, queue the expected return.
   task automatic step(input logic r0, input logic l0, input logic r1, input logic l1,
                       input logic [1:0] eg);
      int unsigned tn;
      ret_t e;
      req0 = r0; lock0 = l0; req1 = r1; lock1 = l1;
      tn = 32'($time);
      #1;
      chk("gnt", {30'd0, gnt1, gnt0}, {30'd0, eg});
      if (eg != 2'b00) begin
         e.id = eg[1];
         e.a  = eg[1] ? exp1_a : exp0_a;
         e.b  = eg[1] ? exp1_b : exp0_b;
         e.t  = tn + 30;
         sb.push_back(e);
      end
      @(negedge clock);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_rvalid0", {31'd0, rvalid0}, 32'd0);
      chk("rst_rvalid1", {31'd0, rvalid1}, 32'd0);
      chk("rst_rf_write", {31'd0, rf_write}, 32'd0);
      chk("rst_rf_D", {16'd0, rf_D}, 32'd0);
      chk("rst_rf_DA", {28'd0, rf_DA}, 32'd0);
      chk("rst_rf_AA", {28'd0, rf_AA}, 32'd0);
      chk("rst_rf_BA", {28'd0, rf_BA}, 32'd0);
      chk("rst_rdata_a", {16'd0, rdata_a}, 32'd0);
      chk("rst_rdata_b", {16'd0, rdata_b}, 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
      set_op0(1'b0, 4'd0, 16'd0, 4'd0, 4'd0, 16'd0, 16'd0);
      set_op1(1'b0, 4'd0, 16'd0, 4'd0, 4'd0, 16'd0, 16'd0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      chk_reset_outputs();

      // Alternation from reset; each op reads what the previous op wrote.
      set_op0(1'b1, 4'd1, 16'h1111, 4'd1, 4'd2, 16'h0000, 16'h0000);
      set_op1(1'b1, 4'd2, 16'h2222, 4'd1, 4'd2, 16'h1111, 16'h0000);
      step(1, 0, 1, 0, 2'b01);
      set_op0(1'b0, 4'd0, 16'h0000, 4'd2, 4'd1, 16'h2222, 16'h1111);
      step(1, 0, 1, 0, 2'b10);
      step(1, 0, 1, 0, 2'b01);
      set_op1(1'b0, 4'd0, 16'h0000, 4'd1, 4'd2, 16'h1111, 16'h2222);
      step(1, 0, 1, 0, 2'b10);
      idle(3);

      // Write r3 then read it back on the next cycle.
      set_op0(1'b1, 4'd3, 16'hBEEF, 4'd0, 4'd0, 16'h0000, 16'h0000);
      step(1, 0, 0, 0, 2'b01);
      set_op0(1'b0, 4'd3, 16'h5A5A, 4'd3, 4'd1, 16'hBEEF, 16'h1111);
      step(1, 0, 0, 0, 2'b01);
      idle(3);
      chk("idle_rf_write", {31'd0, rf_write}, 32'd0);
      chk("idle_rf_D_hold", {16'd0, rf_D}, 32'h5A5A);
      chk("idle_rf_AA_hold", {28'd0, rf_AA}, 32'd3);

      // Same-op read of the written register sees the old value.
      set_op1(1'b1, 4'd5, 16'h1234, 4'd5, 4'd3, 16'h0000, 16'hBEEF);
      step(0, 0, 1, 0, 2'b10);
      idle(3);

      // Locked burst of four, handover, then saturation with requester 1 absent.
      set_op0(1'b0, 4'd0, 16'h0000, 4'd5, 4'd2, 16'h1234, 16'h2222);
      set_op1(1'b0, 4'd0, 16'h0000, 4'd3, 4'd1, 16'hBEEF, 16'h1111);
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 2'b01);
         step(1, 1, 1, 0, 2'b10);
      end
      for (int i = 0; i < 6; i++) step(1, 1, 0, 0, 2'b01);
      step(1, 1, 1, 0, 2'b10);
      idle(3);

      // An idle cycle restarts the burst count.
      step(1, 1, 0, 0, 2'b01);
      step(1, 1, 0, 0, 2'b01);
      idle(1);
      for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 2'b01);
      step(1, 1, 1, 0, 2'b10);
      idle(3);

      // Reset one cycle after an accepted op discards it; reset-cycle requests are ignored.
      set_op1(1'b0, 4'd0, 16'h0000, 4'd3, 4'd5, 16'hBEEF, 16'h1234);
      step(0, 0, 1, 0, 2'b10);
      reset = 1'b1;
      req0 = 1; req1 = 1;
      sb.delete();
      @(negedge clock);
      reset = 1'b0;
      req0 = 0; req1 = 0;
      chk_reset_outputs();
      idle(3);
      step(0, 0, 1, 0, 2'b10);
      idle(4);
      chk("rdata_a_hold", {16'd0, rdata_a}, 32'hBEEF);
      chk("sb_drained", sb.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
